// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: pipelined address/data phases, programmable wait states,
// two-cycle ERROR response and same-word read-after-write forwarding.
module ahb_sram_slave #(
  parameter int          MEM_DEPTH   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HBURST,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int          AW   = $clog2(MEM_DEPTH);
  localparam logic [32:0] SPAN = 33'(MEM_DEPTH) << 2;
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t          r_state, w_state_nxt, w_cap_state;
  logic [3:0]      r_cnt, w_cnt_nxt, w_cap_cnt;
  logic [AW-1:0]   r_idx, w_cap_idx, w_rd_idx;
  logic [3:0]      r_be, w_cap_be;
  logic            r_write, r_burst;
  logic [31:0]     r_hrdata, w_hrdata_nxt, w_rd_word;
  logic [31:0]     r_mem [MEM_DEPTH];

  logic [31:0] w_off;
  logic        w_cap, w_err, w_cap_ok, w_done, w_commit;
  logic        w_unused;

  assign w_off     = HADDR - BASE_ADDR;
  assign w_cap_idx = w_off[AW+1:2];
  assign w_unused  = ^{HBURST, w_off};

  assign HREADY = !((r_state == S_WAIT && r_cnt != 4'd0) || r_state == S_ERR1);
  assign HRESP  = (r_state == S_ERR1 || r_state == S_ERR2) ? 2'b01 : 2'b00;
  assign HRDATA = r_hrdata;

  // SEQ is only legal while a burst is open (last non-BUSY transfer was not IDLE)
  assign w_cap = HREADY && HTRANS[1];
  assign w_err = ({1'b0, w_off} >= SPAN) || (HSIZE > 3'd2)
              || (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
              || (HTRANS == 2'b11 && !r_burst);
  assign w_cap_ok = w_cap && !w_err;

  assign w_done   = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_commit = w_done && r_write;

  always_comb begin
    w_cap_be = 4'b1111;
    case (HSIZE)
      3'd0:    w_cap_be = 4'b0001 << HADDR[1:0];
      3'd1:    w_cap_be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_cap_be = 4'b1111;
    endcase
  end

  always_comb begin
    w_cap_state = S_IDLE;
    w_cap_cnt   = r_cnt;
    if (w_cap && w_err) begin
      w_cap_state = S_ERR1;
    end else if (w_cap) begin
      w_cap_state = S_WAIT;
      w_cap_cnt   = WS;
    end
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = w_cap_state;
          w_cnt_nxt   = w_cap_cnt;
        end
      end
      S_ERR1:  w_state_nxt = S_ERR2;
      default: begin
        w_state_nxt = w_cap_state;
        w_cnt_nxt   = w_cap_cnt;
      end
    endcase
  end

  // Read word, with bytes being committed on this same edge merged in
  assign w_rd_idx = w_cap_ok ? w_cap_idx : r_idx;
  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    for (int i = 0; i < 4; i++) begin
      if (w_commit && r_idx == w_rd_idx && r_be[i]) w_rd_word[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  // HRDATA is registered so it is valid exactly in the completing cycle
  always_comb begin
    w_hrdata_nxt = 32'd0;
    if (w_cap_ok && !HWRITE && WS == 4'd0)
      w_hrdata_nxt = w_rd_word;
    else if (r_state == S_WAIT && r_cnt == 4'd1 && !r_write)
      w_hrdata_nxt = w_rd_word;
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= '0;
      r_be     <= 4'd0;
      r_write  <= 1'b0;
      r_burst  <= 1'b0;
      r_hrdata <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hrdata <= w_hrdata_nxt;
      if (w_cap_ok) begin
        r_idx   <= w_cap_idx;
        r_be    <= w_cap_be;
        r_write <= HWRITE;
      end
      if (HREADY) begin
        if (HTRANS == 2'b00)  r_burst <= 1'b0;
        else if (HTRANS[1])   r_burst <= 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[r_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule
